// File: rtl/timer_mmss.sv
// Minutes:seconds countdown timer with BCD digits, preset load, start/stop/clear
// controls and a prescaler turning TICKS_PER_SEC clock cycles into one second.
module timer_mmss #(
   parameter int TICKS_PER_SEC = 100
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [3:0] data_min,
   input  logic [2:0] data_sec_t,
   input  logic [3:0] data_sec_u,
   input  logic       start,
   input  logic       stop,
   input  logic       clear,
   output logic [3:0] min_u,
   output logic [2:0] sec_t,
   output logic [3:0] sec_u,
   output logic       running,
   output logic       done,
   output logic [1:0] state_o
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_PAUSE = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [15:0] PRE_MAX = 16'(TICKS_PER_SEC - 1);

   logic [1:0]  state_q, state_d;
   logic [15:0] pre_q, pre_d;
   logic [3:0]  min_q, min_d;
   logic [2:0]  sect_q, sect_d;
   logic [3:0]  secu_q, secu_d;

   logic        time_zero;
   logic        tick;
   logic [3:0]  ld_min, ld_secu;
   logic [2:0]  ld_sect;
   logic        borrow_u, borrow_t;
   logic [3:0]  dec_min, dec_secu;
   logic [2:0]  dec_sect;
   logic        dec_zero;

   assign time_zero = (min_q == 4'd0) && (sect_q == 3'd0) && (secu_q == 4'd0);
   assign tick      = (pre_q == PRE_MAX);

   assign ld_min  = (data_min   > 4'd9) ? 4'd9 : data_min;
   assign ld_sect = (data_sec_t > 3'd5) ? 3'd5 : data_sec_t;
   assign ld_secu = (data_sec_u > 4'd9) ? 4'd9 : data_sec_u;

   // One-second decrement with BCD borrow; RUN never holds 0:00, so the minute never underflows.
   assign borrow_u = (secu_q == 4'd0);
   assign borrow_t = borrow_u && (sect_q == 3'd0);
   assign dec_secu = borrow_u ? 4'd9 : secu_q - 4'd1;
   assign dec_sect = borrow_u ? ((sect_q == 3'd0) ? 3'd5 : sect_q - 3'd1) : sect_q;
   assign dec_min  = borrow_t ? min_q - 4'd1 : min_q;
   assign dec_zero = (dec_min == 4'd0) && (dec_sect == 3'd0) && (dec_secu == 4'd0);

   // Only the highest-priority asserted control acts; in RUN the prescaler counts unless stopped.
   always_comb begin
      state_d = state_q;
      pre_d   = pre_q;
      min_d   = min_q;
      sect_d  = sect_q;
      secu_d  = secu_q;
      if (clear) begin
         state_d = S_IDLE;
         pre_d   = 16'd0;
         min_d   = 4'd0;
         sect_d  = 3'd0;
         secu_d  = 4'd0;
      end else if (state_q == S_RUN) begin
         if (stop) begin
            state_d = S_PAUSE;
         end else if (tick) begin
            pre_d  = 16'd0;
            min_d  = dec_min;
            sect_d = dec_sect;
            secu_d = dec_secu;
            if (dec_zero) state_d = S_DONE;
         end else begin
            pre_d = pre_q + 16'd1;
         end
      end else if (stop) begin
         state_d = state_q;
      end else if (start) begin
         if (state_q == S_IDLE && !time_zero) begin
            state_d = S_RUN;
            pre_d   = 16'd0;
         end else if (state_q == S_PAUSE) begin
            state_d = time_zero ? S_IDLE : S_RUN;
         end
      end else if (load) begin
         min_d  = ld_min;
         sect_d = ld_sect;
         secu_d = ld_secu;
         if (state_q == S_DONE) state_d = S_IDLE;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         pre_q   <= 16'd0;
         min_q   <= 4'd0;
         sect_q  <= 3'd0;
         secu_q  <= 4'd0;
      end else begin
         state_q <= state_d;
         pre_q   <= pre_d;
         min_q   <= min_d;
         sect_q  <= sect_d;
         secu_q  <= secu_d;
      end
   end

   assign min_u   = min_q;
   assign sec_t   = sect_q;
   assign sec_u   = secu_q;
   assign running = (state_q == S_RUN);
   assign done    = (state_q == S_DONE);
   assign state_o = state_q;

endmodule

// File: tb/tb_timer_mmss.sv
// Bench for timer_mmss: directed scenarios plus random control traffic, scored
// cycle by cycle against a seconds-based reference model.
module tb_timer_mmss;

   localparam int T = 4;
   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_PAUSE = 2;
   localparam int M_DONE  = 3;

   logic       clk;
   logic       reset;
   logic       load;
   logic [3:0] data_min;
   logic [2:0] data_sec_t;
   logic [3:0] data_sec_u;
   logic       start;
   logic       stop;
   logic       clear;
   logic [3:0] min_u;
   logic [2:0] sec_t;
   logic [3:0] sec_u;
   logic       running;
   logic       done;
   logic [1:0] state_o;

   logic [12:0] exp_q[$];
   int n_checks;
   int n_pass;
   int m_state;
   int m_secs;
   int m_pre;
   string phase;

   timer_mmss #(.TICKS_PER_SEC(T)) dut (
      .clk(clk), .reset(reset), .load(load),
      .data_min(data_min), .data_sec_t(data_sec_t), .data_sec_u(data_sec_u),
      .start(start), .stop(stop), .clear(clear),
      .min_u(min_u), .sec_t(sec_t), .sec_u(sec_u),
      .running(running), .done(done), .state_o(state_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [12:0] model_out();
      logic [3:0] mm;
      logic [2:0] st;
      logic [3:0] su;
      mm = 4'(m_secs / 60);
      st = 3'((m_secs % 60) / 10);
      su = 4'(m_secs % 10);
      return {(m_state == M_RUN), (m_state == M_DONE), mm, st, su};
   endfunction

   task automatic model_reset();
      m_state = M_IDLE;
      m_secs  = 0;
      m_pre   = 0;
   endtask

   // Reference behaviour for one clock edge, using the inputs currently applied.
   task automatic model_step();
      int dm, dt, du;
      if (!reset) begin
         model_reset();
      end else if (clear) begin
         model_reset();
      end else if (m_state == M_RUN) begin
         if (stop) begin
            m_state = M_PAUSE;
         end else if (m_pre == T - 1) begin
            m_pre  = 0;
            m_secs = m_secs - 1;
            if (m_secs == 0) m_state = M_DONE;
         end else begin
            m_pre = m_pre + 1;
         end
      end else if (stop) begin
         m_state = m_state;
      end else if (start) begin
         if (m_state == M_IDLE && m_secs != 0) begin
            m_state = M_RUN;
            m_pre   = 0;
         end else if (m_state == M_PAUSE) begin
            m_state = (m_secs == 0) ? M_IDLE : M_RUN;
         end
      end else if (load) begin
         dm = (int'(data_min) > 9) ? 9 : int'(data_min);
         dt = (int'(data_sec_t) > 5) ? 5 : int'(data_sec_t);
         du = (int'(data_sec_u) > 9) ? 9 : int'(data_sec_u);
         m_secs = dm * 60 + dt * 10 + du;
         if (m_state == M_DONE) m_state = M_IDLE;
      end
   endtask

   task automatic pop_compare(input string name);
      logic [12:0] exp_v;
      logic [12:0] act_v;
      n_checks++;
      if (exp_q.size() == 0) begin
         $display("FAIL %s: no expected entry queued at time %0t", name, $time);
      end else begin
         exp_v = exp_q.pop_front();
         act_v = {running, done, min_u, sec_t, sec_u};
         if (act_v !== exp_v)
            $display("FAIL %s @%0t: got run=%0b done=%0b %0d:%0d%0d, expected run=%0b done=%0b %0d:%0d%0d",
                     name, $time, act_v[12], act_v[11], act_v[10:7], act_v[6:4], act_v[3:0],
                     exp_v[12], exp_v[11], exp_v[10:7], exp_v[6:4], exp_v[3:0]);
         else
            n_pass++;
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() != 0) pop_compare(phase);
   end

   task automatic cycle(input logic ld, input logic [3:0] dm, input logic [2:0] dt,
                        input logic [3:0] du, input logic st, input logic sp, input logic cl);
      load = ld; data_min = dm; data_sec_t = dt; data_sec_u = du;
      start = st; stop = sp; clear = cl;
      @(posedge clk);
      #1;
      model_step();
      exp_q.push_back(model_out());
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 4'd0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_load(input logic [3:0] dm, input logic [2:0] dt, input logic [3:0] du);
      cycle(1'b1, dm, dt, du, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_start();
      cycle(1'b0, 4'd0, 3'd0, 4'd0, 1'b1, 1'b0, 1'b0);
   endtask

   // Reset asserted between edges must act at once; inputs while held low are noise.
   task automatic pulse_reset();
      @(negedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      #1;
      exp_q.push_back(model_out());
      pop_compare("async_reset");
      cycle(1'b1, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
            4'($urandom_range(0, 15)), 1'b1, 1'b0, 1'b0);
      reset = 1'b1;
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      phase    = "reset_state";
      reset = 1'b0; load = 1'b0; data_min = 4'd0; data_sec_t = 3'd0; data_sec_u = 4'd0;
      start = 1'b0; stop = 1'b0; clear = 1'b0;
      model_reset();
      #1;
      exp_q.push_back(model_out());
      pop_compare("reset_state");
      cycle(1'b1, 4'd5, 3'd3, 4'd2, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 4'd0, 3'd0, 4'd0, 1'b1, 1'b0, 1'b0);
      reset = 1'b1;

      phase = "start_at_zero";
      do_start();
      idle(3);

      phase = "countdown_1_05";
      do_load(4'd1, 3'd0, 4'd5);
      do_start();
      idle(262);

      phase = "done_hold";
      do_start();
      idle(2);
      do_load(4'd0, 3'd1, 4'd0);
      idle(2);
      cycle(1'b0, 4'd0, 3'd0, 4'd0, 1'b1, 1'b0, 1'b1);
      idle(2);

      phase = "pause_resume";
      do_load(4'd0, 3'd3, 4'd0);
      do_start();
      idle(6);
      cycle(1'b0, 4'd0, 3'd0, 4'd0, 1'b0, 1'b1, 1'b0);
      idle(20);
      do_start();
      idle(10);
      cycle(1'b0, 4'd0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b1);

      phase = "clamp_and_load_in_run";
      do_load(4'd12, 3'd7, 4'd15);
      idle(2);
      do_start();
      for (int i = 0; i < 20; i++)
         cycle(1'b1, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
               4'($urandom_range(0, 15)), 1'b0, 1'b0, 1'b0);

      phase = "reset_mid_run";
      do_load(4'd0, 3'd0, 4'd2);
      do_start();
      idle(5);
      pulse_reset();
      do_start();
      idle(3);

      phase = "random";
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 299) == 0) begin
            pulse_reset();
         end else begin
            cycle(($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0,
                  3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 14) == 0),
                  ($urandom_range(0, 39) == 0));
         end
      end

      @(negedge clk);
      #1;
      n_checks++;
      if (exp_q.size() != 0)
         $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
      else
         n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
